// File: rtl/sram_dp_clr.sv
// -----------------------------------------------------------------------------
// sram_dp_clr
// Simple dual-port SRAM (one write port, one read port) with an automatic
// clear sequence. After reset the block walks every location and writes
// INIT_VALUE, holding busy high. Once the walk completes, normal port
// accesses are accepted.
//
// Parameters
//   DATA_WIDTH  word width in bits
//   ADDR_WIDTH  address width in bits
//   DEPTH       number of words (1 .. 2^ADDR_WIDTH)
//   BYPASS      1: same-address read returns new write data, 0: old data
//   INIT_VALUE  word written to every location by the clear sequence
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   wr         write strobe
//   wrAddr     write address
//   dataIn     write data
//   rd         read strobe
//   rdAddr     read address
//   dataOut    registered read data (held when no read)
//   dataValid  one-cycle pulse when dataOut was loaded by a read
//   busy       clear sequence in progress; wr/rd ignored
// -----------------------------------------------------------------------------
module sram_dp_clr #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    DEPTH      = 256,
    parameter int                    BYPASS     = 1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = {DATA_WIDTH{1'b0}}
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr,
    input  logic [ADDR_WIDTH-1:0] wrAddr,
    input  logic [DATA_WIDTH-1:0] dataIn,
    input  logic                  rd,
    input  logic [ADDR_WIDTH-1:0] rdAddr,
    output logic [DATA_WIDTH-1:0] dataOut,
    output logic                  dataValid,
    output logic                  busy
);

    // One extra bit so DEPTH == 2^ADDR_WIDTH is representable.
    localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    // True when an address maps onto a real storage location.
    function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] a);
        return ({1'b0, a} < DEPTH_W);
    endfunction

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic [DATA_WIDTH-1:0] r_dataOut;
    logic                  r_dataValid;
    logic                  r_busy;

    logic                  w_we;
    logic [ADDR_WIDTH-1:0] w_waddr;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [DATA_WIDTH-1:0] w_rdata;

    // Write-port mux: the clear walker owns the array while clearing,
    // otherwise in-range port writes go through; out-of-range ones are dropped.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = {ADDR_WIDTH{1'b0}};
        w_wdata = {DATA_WIDTH{1'b0}};
        if (r_state == CLEAR) begin
            w_we    = 1'b1;
            w_waddr = r_cnt;
            w_wdata = INIT_VALUE;
        end else if (wr && addr_in_range(wrAddr)) begin
            w_we    = 1'b1;
            w_waddr = wrAddr;
            w_wdata = dataIn;
        end else begin
            w_we    = 1'b0;
        end
    end

    // Read-data selection: out-of-range reads return zero; a same-address
    // collision forwards dataIn only when BYPASS is enabled, otherwise the
    // array's pre-write word is returned.
    always_comb begin
        w_rdata = {DATA_WIDTH{1'b0}};
        if (!addr_in_range(rdAddr)) begin
            w_rdata = {DATA_WIDTH{1'b0}};
        end else if ((BYPASS != 0) && wr && (wrAddr == rdAddr)) begin
            w_rdata = dataIn;
        end else begin
            w_rdata = r_mem[rdAddr];
        end
    end

    // Storage array; intentionally not reset so it maps onto RAM macros.
    // Contents are made defined by the clear walk instead.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    // Control FSM with registered outputs: clear walk, then port service.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= CLEAR;
            r_cnt       <= {ADDR_WIDTH{1'b0}};
            r_dataOut   <= {DATA_WIDTH{1'b0}};
            r_dataValid <= 1'b0;
            r_busy      <= 1'b1;
        end else begin
            case (r_state)
                CLEAR: begin
                    r_dataValid <= 1'b0;
                    if (r_cnt == LAST_ADDR) begin
                        r_state <= READY;
                        r_busy  <= 1'b0;
                        r_cnt   <= {ADDR_WIDTH{1'b0}};
                    end else begin
                        r_busy  <= 1'b1;
                        r_cnt   <= r_cnt + ADDR_WIDTH'(1);
                    end
                end
                READY: begin
                    r_busy <= 1'b0;
                    if (rd) begin
                        r_dataOut   <= w_rdata;
                        r_dataValid <= 1'b1;
                    end else begin
                        r_dataValid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= CLEAR;
                    r_cnt       <= {ADDR_WIDTH{1'b0}};
                    r_dataValid <= 1'b0;
                    r_busy      <= 1'b1;
                end
            endcase
        end
    end

    assign dataOut   = r_dataOut;
    assign dataValid = r_dataValid;
    assign busy      = r_busy;

endmodule

// File: tb/tb_sram_dp_clr.sv
// -----------------------------------------------------------------------------
// tb_sram_dp_clr
// Drives three sram_dp_clr instances with identical stimulus:
//   u0: defaults (DEPTH 256, BYPASS 1)
//   u1: BYPASS 0
//   u2: DEPTH 200
// A behavioural model per instance predicts busy, held dataOut and every
// read response; predicted reads go into a queue that a separate monitor
// pops when the DUT raises dataValid.
// -----------------------------------------------------------------------------
module tb_sram_dp_clr;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr  = 1'b0;
    logic       rd  = 1'b0;
    logic [7:0] wrAddr = 8'h00;
    logic [7:0] rdAddr = 8'h00;
    logic [7:0] dataIn = 8'h00;

    logic [7:0] dout [3];
    logic       dv   [3];
    logic       bsy  [3];

    initial forever #5 clk = ~clk;

    sram_dp_clr u0 (
        .clk(clk), .rst(rst), .wr(wr), .wrAddr(wrAddr), .dataIn(dataIn),
        .rd(rd), .rdAddr(rdAddr), .dataOut(dout[0]), .dataValid(dv[0]), .busy(bsy[0])
    );

    sram_dp_clr #(.BYPASS(0)) u1 (
        .clk(clk), .rst(rst), .wr(wr), .wrAddr(wrAddr), .dataIn(dataIn),
        .rd(rd), .rdAddr(rdAddr), .dataOut(dout[1]), .dataValid(dv[1]), .busy(bsy[1])
    );

    sram_dp_clr #(.DEPTH(200)) u2 (
        .clk(clk), .rst(rst), .wr(wr), .wrAddr(wrAddr), .dataIn(dataIn),
        .rd(rd), .rdAddr(rdAddr), .dataOut(dout[2]), .dataValid(dv[2]), .busy(bsy[2])
    );

    // Reference model state
    int         depth_c [3] = '{256, 256, 200};
    int         byp_c   [3] = '{1, 0, 1};
    logic [7:0] mem_m   [3][256];
    int         since_m [3];      // clearing edges seen since reset release
    logic [7:0] last_m  [3];
    logic       busy_m  [3];

    typedef struct {
        logic [7:0] d;
        int         c;
    } exp_t;
    exp_t sb [3][$];

    int cyc    = 0;
    int n_chk  = 0;
    int n_fail = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string nm, input int inst,
                         input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s u%0d cycle %0d: got %0h expected %0h", nm, inst, cyc, act, exp);
        end
    endtask

    // Monitor: compare outputs on the falling edge, away from the active edge.
    initial forever begin
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            logic exp_v;
            exp_t e;
            check("busy", i, 32'(bsy[i]), 32'(busy_m[i]));
            check("dataOut", i, 32'(dout[i]), 32'(last_m[i]));
            exp_v = (sb[i].size() != 0) && (sb[i][0].c == cyc);
            check("dataValid", i, 32'(dv[i]), 32'(exp_v));
            if (exp_v) begin
                e = sb[i].pop_front();
                check("read_data", i, 32'(dout[i]), 32'(e.d));
            end
        end
    end

    // Apply one cycle of inputs and predict what the next rising edge does.
    task automatic step(input logic r, input logic w, input logic [7:0] wa,
                        input logic [7:0] di, input logic rv, input logic [7:0] ra);
        logic [7:0] v;
        @(negedge clk);
        #1;
        rst = r; wr = w; wrAddr = wa; dataIn = di; rd = rv; rdAddr = ra;
        for (int i = 0; i < 3; i++) begin
            if (r) begin
                since_m[i] = 0;
                busy_m[i]  = 1'b1;
                last_m[i]  = 8'h00;
            end else if (since_m[i] < depth_c[i]) begin
                since_m[i]++;
                if (since_m[i] == depth_c[i]) begin
                    for (int a = 0; a < depth_c[i]; a++) mem_m[i][a] = 8'h00;
                    busy_m[i] = 1'b0;
                end else begin
                    busy_m[i] = 1'b1;
                end
            end else begin
                busy_m[i] = 1'b0;
                if (rv) begin
                    if (int'(ra) >= depth_c[i])              v = 8'h00;
                    else if (w && wa == ra && byp_c[i] == 1) v = di;
                    else                                     v = mem_m[i][ra];
                    sb[i].push_back('{v, cyc + 1});
                    last_m[i] = v;
                end
                if (w && int'(wa) < depth_c[i]) mem_m[i][wa] = di;
            end
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
    endtask

    task automatic rnd_step();
        logic [7:0] wa, ra;
        wa = 8'($urandom_range(0, 255));
        ra = ($urandom_range(0, 3) == 0) ? wa : 8'($urandom_range(0, 255));
        step(1'b0, 1'($urandom_range(0, 1)), wa, 8'($urandom), 1'($urandom_range(0, 1)), ra);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            since_m[i] = 0;
            busy_m[i]  = 1'b1;
            last_m[i]  = 8'h00;
        end

        // Reset, then the full clear walk
        repeat (3) step(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
        repeat (256) idle();

        // Back-to-back sweep: everything cleared; u2 reads beyond 199 give 0
        for (int a = 0; a < 256; a++) step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'(a));

        // Writes 0..9 with 50..59, then read back
        for (int a = 0; a < 10; a++) step(1'b0, 1'b1, 8'(a), 8'(50 + a), 1'b0, 8'h00);
        for (int a = 0; a < 10; a++) step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'(a));

        // Same-address collision at 0x20
        step(1'b0, 1'b1, 8'h20, 8'h11, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h20, 8'hA5, 1'b1, 8'h20);
        step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h20);
        idle();

        // Out-of-range write/read for u2, then confirm 0..199 untouched
        step(1'b0, 1'b1, 8'd210, 8'h77, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'd210);
        for (int a = 0; a < 200; a++) step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'(a));

        // Random traffic
        repeat (1500) rnd_step();

        // Write then reset mid-READY: location must come back as INIT_VALUE
        step(1'b0, 1'b1, 8'd5, 8'h3C, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
        repeat (256) idle();
        step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'd5);

        // Reset, clear 100 edges under ignored traffic, reset again
        step(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
        repeat (100) rnd_step();
        step(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
        repeat (256) rnd_step();
        for (int a = 0; a < 256; a++) step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'(a));
        repeat (300) rnd_step();

        repeat (3) idle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_dp_clr.md
SRAM_DP_CLR -- requirements
Module: sram_dp_clr

Interface
REQ-001 The block SHALL use one clock and one reset; reset is asynchronous and active-high.
REQ-002 Parameters SHALL be, one per line: name, default, meaning.
 DATA_WIDTH  8    word width in bits
 ADDR_WIDTH  8    address width in bits
 DEPTH       256  number of words, 1 <= DEPTH <= 2^ADDR_WIDTH
 BYPASS      1    1 = same-address read returns new write data; 0 = returns old data
 INIT_VALUE  0    word written to every location by the clear sequence
REQ-003 Ports SHALL be, one per line: name  direction  width  meaning.
 clk      in   1           rising-edge clock
 rst      in   1           asynchronous active-high reset
 wr       in   1           write strobe
 wrAddr   in   ADDR_WIDTH  write address
 dataIn   in   DATA_WIDTH  write data
 rd       in   1           read strobe
 rdAddr   in   ADDR_WIDTH  read address
 dataOut  out  DATA_WIDTH  registered read data
 dataValid out 1           one-cycle pulse: dataOut updated by a read this cycle
 busy     out  1           clear sequence in progress; wr/rd ignored

Function
REQ-004 FSM states SHALL be CLEAR and READY; rst forces CLEAR with clear counter = 0.
REQ-005 In CLEAR, each rising edge SHALL write INIT_VALUE to location counter and increment counter.
REQ-006 After the edge that writes location DEPTH-1, the FSM SHALL enter READY; busy SHALL be 1 in CLEAR and 0 in READY.
REQ-007 Clearing SHALL take exactly DEPTH edges after rst deasserts; busy SHALL fall after the DEPTH-th edge.
REQ-008 While busy=1, wr and rd SHALL be ignored: no memory write from the port, dataValid=0, dataOut held.
REQ-009 In READY, wr=1 at a rising edge SHALL store dataIn at wrAddr.
REQ-010 In READY, rd=1 at a rising edge SHALL load dataOut with the word at rdAddr and assert dataValid for that cycle only (latency 1).
REQ-011 When rd=0, dataOut SHALL hold its last value and dataValid SHALL be 0.
REQ-012 Simultaneous wr and rd at different addresses SHALL both complete in the same cycle.
REQ-013 Simultaneous wr and rd at the same address SHALL return dataIn if BYPASS=1, else the pre-write word; the write SHALL complete in both cases.
REQ-014 A write with wrAddr >= DEPTH SHALL be dropped without altering any location.
REQ-015 A read with rdAddr >= DEPTH SHALL return 0 with dataValid=1.
REQ-016 Back-to-back reads on consecutive cycles SHALL each produce one valid word per cycle with no bubbles.

Reset
REQ-017 While rst=1: dataOut=0, dataValid=0, busy=1, FSM=CLEAR, counter=0.
REQ-018 rst asserted mid-CLEAR or mid-READY SHALL abort the current activity at once and restart the full clear from location 0 once released.
REQ-019 Memory contents SHALL be undefined during rst and SHALL equal INIT_VALUE everywhere once busy falls.

Verification
REQ-020 Defaults; release rst, count edges -> busy falls after exactly 256 edges; read addrs 0..255 -> all return 0.
REQ-021 Write addrs 0..9 with data 50..59, then read 0..9 -> dataOut 50..59, one dataValid pulse per read, latency 1.
REQ-022 Same-cycle wr and rd at addr 0x20, dataIn=0xA5, old=0x11 -> 0xA5 when BYPASS=1; 0x11 when BYPASS=0; a later read returns 0xA5.
REQ-023 DEPTH=200: write 0x77 to addr 210, read addr 210 -> dataOut 0, dataValid 1; addrs 0..199 unchanged.
REQ-024 Assert rst for 1 cycle at clear edge 100, then release -> busy stays high for 256 further edges; wr/rd during busy -> no effect, dataValid 0.
REQ-025 Write 0x3C to addr 5, then reset -> after clear, read addr 5 returns INIT_VALUE (0).
